// File: rtl/timing_pkg.sv
// timing_pkg
// Shared definitions for the timing-exercise sequencer blocks.
//   TIMING_WIDTH_DEF : default one-hot ring width
//   TIMING_DEPTH_DEF : default input delay-line depth
//   rot_dir_t        : decoding of the ring rotate direction input
package timing_pkg;

  localparam int TIMING_WIDTH_DEF = 16;
  localparam int TIMING_DEPTH_DEF = 2;

  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_t;

endpackage : timing_pkg

// File: rtl/delay_line_edge.sv
// delay_line_edge
// DEPTH-stage flop chain for an input of asynchronous origin, with registered
// rising/falling edge pulses aligned to the cycle in which XD changes.
// Ports:
//   CLK  : clock, all state on posedge
//   R    : synchronous active-high reset, clears every stage and both pulses
//   X    : input sampled into stage 0
//   XD   : X delayed by DEPTH edges (last stage)
//   RISE : high for the one cycle in which XD went 0->1
//   FALL : high for the one cycle in which XD went 1->0
module delay_line_edge #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic R,
  input  logic X,
  output logic XD,
  output logic RISE,
  output logic FALL
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], X};
    // The last stage takes the value of stage DEPTH-2 on this edge, so
    // comparing the two pre-edge values predicts the change XD is about to
    // make; registering the result lines the pulse up with the new XD.
    rise_d  =  stage_q[DEPTH-2] & ~stage_q[DEPTH-1];
    fall_d  = ~stage_q[DEPTH-2] &  stage_q[DEPTH-1];
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      stage_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign XD   = stage_q[DEPTH-1];
  assign RISE = rise_q;
  assign FALL = fall_q;

endmodule : delay_line_edge

// File: rtl/onehot_ring_seq.sv
// onehot_ring_seq
// One-hot ring sequencer: a WIDTH-bit ring register rotated left/right on
// enable, a registered (ring - 1) mask, a wrap pulse, and a DEPTH-stage input
// delay line with registered edge detection.
// Optional feature: define ONEHOT_RING_CHECK_EN to build the sticky
// non-one-hot checker driving ERR; otherwise ERR is tied low.
// Ports:
//   CLK      : clock, all state on posedge
//   R        : synchronous active-high reset, overrides every other input
//   EN       : rotate enable
//   DIR      : 0 rotate left (towards MSB), 1 rotate right
//   LOAD     : load LOAD_VAL into the ring (beats EN)
//   LOAD_VAL : value to load, need not be one-hot
//   X        : delay line input
//   XD       : X delayed by DEPTH edges
//   RISE     : one-cycle pulse when XD goes 0->1
//   FALL     : one-cycle pulse when XD goes 1->0
//   ONEHOT   : ring register
//   MASK     : ONEHOT - 1 from the previous cycle (mod 2^WIDTH)
//   WRAP     : one-cycle pulse while the wrapped ring value is visible
//   ERR      : sticky non-one-hot flag
module onehot_ring_seq
  import timing_pkg::*;
#(
  parameter int WIDTH = TIMING_WIDTH_DEF,
  parameter int DEPTH = TIMING_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic             DIR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             X,
  output logic             XD,
  output logic             RISE,
  output logic             FALL,
  output logic [WIDTH-1:0] ONEHOT,
  output logic [WIDTH-1:0] MASK,
  output logic             WRAP,
  output logic             ERR
);

  rot_dir_t         dir_e;
  logic [WIDTH-1:0] onehot_q;
  logic [WIDTH-1:0] onehot_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             wrap_q;
  logic             wrap_d;

  assign dir_e = rot_dir_t'(DIR);

  always_comb begin
    onehot_d = onehot_q;
    wrap_d   = 1'b0;
    if (LOAD) begin
      onehot_d = LOAD_VAL;
    end else if (EN) begin
      if (dir_e == ROT_RIGHT) begin
        onehot_d = {onehot_q[0], onehot_q[WIDTH-1:1]};
        wrap_d   = onehot_q[0];
      end else begin
        onehot_d = {onehot_q[WIDTH-2:0], onehot_q[WIDTH-1]};
        wrap_d   = onehot_q[WIDTH-1];
      end
    end
    // Mask follows the pre-edge ring on every edge; zero underflows to all ones.
    mask_d = onehot_q - WIDTH'(1);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      onehot_q <= WIDTH'(1);
      mask_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      mask_q   <= mask_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef ONEHOT_RING_CHECK_EN
  logic err_q;
  logic err_d;

  // Checks the current ring value, so a bad load shows on ERR one edge after
  // it shows on ONEHOT. Only reset clears it.
  always_comb begin
    err_d = err_q | ~$onehot(onehot_q);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  delay_line_edge #(
    .DEPTH (DEPTH)
  ) u_delay_line_edge (
    .CLK  (CLK),
    .R    (R),
    .X    (X),
    .XD   (XD),
    .RISE (RISE),
    .FALL (FALL)
  );

  assign ONEHOT = onehot_q;
  assign MASK   = mask_q;
  assign WRAP   = wrap_q;

endmodule : onehot_ring_seq

// File: tb/tb_onehot_ring_seq.sv
module tb_onehot_ring_seq;

  logic        clk;
  logic        r;
  logic        en;
  logic        dir;
  logic        load;
  logic [15:0] load_val;
  logic        x;
  logic        xd;
  logic        rise;
  logic        fall;
  logic [15:0] onehot;
  logic [15:0] mask;
  logic        wrap;
  logic        err;

  // second build: WIDTH=4, DEPTH=4
  logic        en4;
  logic        x4;
  logic        load4;
  logic [3:0]  load_val4;
  logic        xd4;
  logic        rise4;
  logic        fall4;
  logic [3:0]  onehot4;
  logic [3:0]  mask4;
  logic        wrap4;
  logic        err4;

  int n_checks;
  int n_errors;
  logic exp_err_bad;

  onehot_ring_seq #(.WIDTH(16), .DEPTH(2)) u_dut (
    .CLK      (clk),
    .R        (r),
    .EN       (en),
    .DIR      (dir),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .X        (x),
    .XD       (xd),
    .RISE     (rise),
    .FALL     (fall),
    .ONEHOT   (onehot),
    .MASK     (mask),
    .WRAP     (wrap),
    .ERR      (err)
  );

  onehot_ring_seq #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .CLK      (clk),
    .R        (r),
    .EN       (en4),
    .DIR      (1'b0),
    .LOAD     (load4),
    .LOAD_VAL (load_val4),
    .X        (x4),
    .XD       (xd4),
    .RISE     (rise4),
    .FALL     (fall4),
    .ONEHOT   (onehot4),
    .MASK     (mask4),
    .WRAP     (wrap4),
    .ERR      (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%0h", tag, got);
    end
  endtask

  // advance one edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ring(input string tag, input logic [15:0] e_oh,
                            input logic [15:0] e_mask, input logic e_wrap);
    check({tag, ".onehot"}, 32'(onehot), 32'(e_oh));
    check({tag, ".mask"},   32'(mask),   32'(e_mask));
    check({tag, ".wrap"},   32'(wrap),   32'(e_wrap));
  endtask

  task automatic check_x(input string tag, input logic e_xd, input logic e_rise, input logic e_fall);
    check({tag, ".xd"},   32'(xd),   32'(e_xd));
    check({tag, ".rise"}, 32'(rise), 32'(e_rise));
    check({tag, ".fall"}, 32'(fall), 32'(e_fall));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef ONEHOT_RING_CHECK_EN
    exp_err_bad = 1'b1;
`else
    exp_err_bad = 1'b0;
`endif
    r = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 16'h0; x = 1'b0;
    en4 = 1'b0; x4 = 1'b0; load4 = 1'b0; load_val4 = 4'h0;
    #2;
    step();
    step();
    check_ring("reset", 16'h0001, 16'h0000, 1'b0);
    check_x("reset", 1'b0, 1'b0, 1'b0);
    check("reset.err", 32'(err), 32'd0);
    check("reset.w4.onehot", 32'(onehot4), 32'h1);

    // left rotation through a full period
    r = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_ring($sformatf("left%0d", i), 16'h1 << (i % 16),
                 (16'h1 << ((i - 1) % 16)) - 16'h1, (i == 16));
    end

    // right rotation wraps 0x0001 -> 0x8000, then hold
    dir = 1'b1;
    step();
    check_ring("right_wrap", 16'h8000, 16'h0000, 1'b1);
    en = 1'b0;
    step();
    check_ring("hold", 16'h8000, 16'h7FFF, 1'b0);

    // LOAD beats EN; DIR=0 with MSB set would otherwise wrap
    load = 1'b1; load_val = 16'h0000; en = 1'b1; dir = 1'b0;
    step();
    check_ring("load_zero", 16'h0000, 16'h7FFF, 1'b0);
    check("load_zero.err", 32'(err), 32'd0);
    load = 1'b0;
    step();
    check_ring("zero_rot", 16'h0000, 16'hFFFF, 1'b0);
    check("zero_rot.err", 32'(err), 32'(exp_err_bad));
    en = 1'b0;

    // X held high from edge 0
    x = 1'b1;
    step();
    check_x("xrise_e0", 1'b0, 1'b0, 1'b0);
    step();
    check_x("xrise_e1", 1'b1, 1'b1, 1'b0);
    step();
    check_x("xrise_e2", 1'b1, 1'b0, 1'b0);
    x = 1'b0;
    step();
    step();
    check_x("xfall", 1'b0, 1'b0, 1'b1);
    step();
    check_x("xfall_after", 1'b0, 1'b0, 1'b0);

    // one-cycle X pulse
    x = 1'b1;
    step();
    x = 1'b0;
    step();
    check_x("pulse_a", 1'b1, 1'b1, 1'b0);
    step();
    check_x("pulse_b", 1'b0, 1'b0, 1'b1);
    step();
    check_x("pulse_c", 1'b0, 1'b0, 1'b0);

    // reset mid-activity overrides EN, LOAD and X
    load = 1'b1; load_val = 16'h0100; x = 1'b1;
    step();
    load = 1'b0;
    step();
    check("pre_rst.onehot", 32'(onehot), 32'h0100);
    check("pre_rst.xd", 32'(xd), 32'd1);
    check("pre_rst.err", 32'(err), 32'(exp_err_bad));
    r = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'hFFFF; x = 1'b1;
    step();
    check_ring("rst_mid", 16'h0001, 16'h0000, 1'b0);
    check_x("rst_mid", 1'b0, 1'b0, 1'b0);
    check("rst_mid.err", 32'(err), 32'd0);
    r = 1'b0; en = 1'b0; load = 1'b0; x = 1'b0;

    // WIDTH=4, DEPTH=4 instance: ring period 4, X latency 4 edges
    en4 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("w4_rot%0d.onehot", i), 32'(onehot4), 32'(4'h1 << (i % 4)));
      check($sformatf("w4_rot%0d.wrap", i), 32'(wrap4), 32'((i % 4) == 0));
    end
    en4 = 1'b0;
    x4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("w4_x_e%0d.xd", i), 32'(xd4), 32'(i >= 3));
      check($sformatf("w4_x_e%0d.rise", i), 32'(rise4), 32'(i == 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_onehot_ring_seq
